// File: rtl/lapido_prog_loader.sv
// LAPIDO program loader.
// Parses a framed byte stream from the UART receiver and writes big-endian
// 32-bit words into instruction memory. The core stays in reset until an
// image with a matching XOR checksum has been completely written.
//
// Frame: START_BYTE, LEN_HI, LEN_LO, 4*LEN data bytes (MSB first), CHK
//
// state        | meaning
// -------------+---------------------------------------------------------
// S_WAIT_START | idle after reset, discard bytes until START_BYTE
// S_LEN_HI     | expect upper byte of word count
// S_LEN_LO     | expect lower byte of word count, range-check it
// S_DATA       | collect 4 bytes of a word, fold them into the checksum
// S_WRITE      | one-cycle memory write, receiver stalled
// S_CHECK      | expect checksum byte
// S_DONE       | image valid, core released (sticky until next START_BYTE)
// S_ERROR      | frame aborted, core held in reset (sticky until START_BYTE)
module lapido_prog_loader #(
  parameter int          ADDR_WIDTH     = 10,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  START_BYTE     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst_n,
  output logic                  load_done,
  output logic                  load_error,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {
    S_WAIT_START,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int              TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  // Largest legal word count; 17 bits so a full 16-bit address space still fits.
  localparam logic [16:0]     MAX_LEN  = 17'(1) << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            chk_q, chk_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           word_q, word_d;
  logic [15:0]           words_q, words_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  logic        accept;
  logic        tmo_active;
  logic        tmo_hit;
  logic        is_start;
  logic [16:0] len_full;

  assign accept     = rx_valid && rx_ready;
  assign tmo_active = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CHECK);
  // An accept in the expiry cycle wins over the timeout.
  assign tmo_hit    = tmo_active && !accept && (tmo_q == TMO_LAST);
  assign is_start   = accept && (rx_data == START_BYTE);
  assign len_full   = {1'b0, len_q[15:8], rx_data};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_WAIT_START;
    else      state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_START, S_DONE, S_ERROR: begin
        if (is_start) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept)       state_d = S_LEN_LO;
        else if (tmo_hit) state_d = S_ERROR;
      end
      S_LEN_LO: begin
        if (accept) begin
          if (len_full > MAX_LEN)    state_d = S_ERROR;
          else if (len_full == '0)   state_d = S_CHECK;
          else                       state_d = S_DATA;
        end else if (tmo_hit) begin
          state_d = S_ERROR;
        end
      end
      S_DATA: begin
        if (accept && (idx_q == 2'd3)) state_d = S_WRITE;
        else if (tmo_hit)              state_d = S_ERROR;
      end
      S_WRITE: begin
        if ((17'(words_q) + 17'd1) < 17'(len_q)) state_d = S_DATA;
        else                                     state_d = S_CHECK;
      end
      S_CHECK: begin
        if (accept)       state_d = (rx_data == chk_q) ? S_DONE : S_ERROR;
        else if (tmo_hit) state_d = S_ERROR;
      end
      default: state_d = S_WAIT_START;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    rx_ready   = (state_q != S_WRITE);
    imem_we    = (state_q == S_WRITE);
    load_done  = (state_q == S_DONE);
    core_rst_n = (state_q == S_DONE);
    load_error = (state_q == S_ERROR);
  end

  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign words_loaded = words_q;

  // Datapath next values: length, word assembly, checksum, write port, timeout.
  always_comb begin
    len_d   = len_q;
    chk_d   = chk_q;
    idx_d   = idx_q;
    word_d  = word_q;
    words_d = words_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tmo_d   = '0;
    if (tmo_active && !accept) tmo_d = tmo_q + TW'(1);
    case (state_q)
      S_WAIT_START, S_DONE, S_ERROR: begin
        if (is_start) begin
          len_d   = '0;
          chk_d   = '0;
          idx_d   = '0;
          words_d = '0;
        end
      end
      S_LEN_HI: begin
        if (accept) len_d[15:8] = rx_data;
      end
      S_LEN_LO: begin
        if (accept) len_d[7:0] = rx_data;
      end
      S_DATA: begin
        if (accept) begin
          word_d = {word_q[23:0], rx_data};
          chk_d  = chk_q ^ rx_data;
          idx_d  = idx_q + 2'd1;
          // Latch the write port here so it is valid during S_WRITE and
          // holds afterwards.
          if (idx_q == 2'd3) begin
            addr_d  = words_q[ADDR_WIDTH-1:0];
            wdata_d = {word_q[23:0], rx_data};
          end
        end
      end
      S_WRITE: begin
        words_d = words_q + 16'd1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q   <= '0;
      chk_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      words_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      tmo_q   <= '0;
    end else begin
      len_q   <= len_d;
      chk_q   <= chk_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_lapido_prog_loader.sv
// Directed bench for the program loader: good/bad checksum, zero and
// oversize length, full-capacity image, timeout, reset mid-frame.
module tb_lapido_prog_loader;

  localparam int AW  = 10;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          load_done;
  logic          load_error;
  logic [15:0]   words_loaded;

  lapido_prog_loader #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TMO),
    .START_BYTE     (8'hA5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_rst_n   (core_rst_n),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  int            rdy_low    = 0;
  int            rdy_we_mis = 0;

  // Log memory writes and receiver stalls, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (imem_we) begin
        wa_q.push_back(imem_addr);
        wd_q.push_back(imem_wdata);
      end
      if (!rx_ready) rdy_low++;
      if ((!rx_ready) !== imem_we) rdy_we_mis++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    rdy_low    = 0;
    rdy_we_mis = 0;
  endtask

  // Offer one byte and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n        = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("send_ready_bound", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(8'hA5);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  function automatic logic [31:0] word_of(input int i);
    logic [15:0] v;
    v = 16'(i);
    return {v[15:8], v[7:0], ~v[7:0], 8'h5A};
  endfunction

  function automatic logic [31:0] wa_at(input int i);
    return (wa_q.size() > i) ? 32'(wa_q[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] wd_at(input int i);
    return (wd_q.size() > i) ? wd_q[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    logic [7:0] chk;
    int         bad;

    // Reset values while rst is held low.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rx_ready",   {31'd0, rx_ready},   32'd1);
    check_eq("rst_imem_we",    {31'd0, imem_we},    32'd0);
    check_eq("rst_imem_addr",  32'(imem_addr),      32'd0);
    check_eq("rst_imem_wdata", imem_wdata,          32'd0);
    check_eq("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    check_eq("rst_load_done",  {31'd0, load_done},  32'd0);
    check_eq("rst_load_error", {31'd0, load_error}, 32'd0);
    check_eq("rst_words",      32'(words_loaded),   32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Good 2-word frame; checksum = 00^00^00^20^12^34^56^78 = 28.
    clear_log();
    send_hdr(16'd2);
    send_word(32'h0000_0020);
    check_eq("lat_we",    {31'd0, imem_we}, 32'd1);
    check_eq("lat_addr",  32'(imem_addr),   32'd0);
    check_eq("lat_wdata", imem_wdata,       32'h0000_0020);
    check_eq("load_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    send_word(32'h1234_5678);
    send_byte(8'h28);
    check_eq("good_done",     {31'd0, load_done},  32'd1);
    check_eq("good_core_rst", {31'd0, core_rst_n}, 32'd1);
    check_eq("good_err",      {31'd0, load_error}, 32'd0);
    check_eq("good_words",    32'(words_loaded),   32'd2);
    check_eq("good_nwr",      wa_q.size(),         32'd2);
    check_eq("good_a0",       wa_at(0),            32'd0);
    check_eq("good_d0",       wd_at(0),            32'h0000_0020);
    check_eq("good_a1",       wa_at(1),            32'd1);
    check_eq("good_d1",       wd_at(1),            32'h1234_5678);
    check_eq("good_rdy_low",  rdy_low,             32'd2);
    check_eq("good_rdy_we",   rdy_we_mis,          32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("hold_addr",  32'(imem_addr), 32'd1);
    check_eq("hold_wdata", imem_wdata,     32'h1234_5678);
    check_eq("hold_done",  {31'd0, load_done}, 32'd1);

    // Same frame with a wrong checksum, then restart.
    clear_log();
    send_hdr(16'd2);
    send_word(32'h0000_0020);
    send_word(32'h1234_5678);
    send_byte(8'h00);
    check_eq("bad_err",      {31'd0, load_error}, 32'd1);
    check_eq("bad_core_rst", {31'd0, core_rst_n}, 32'd0);
    check_eq("bad_done",     {31'd0, load_done},  32'd0);
    check_eq("bad_nwr",      wa_q.size(),         32'd2);
    send_byte(8'h33);
    check_eq("err_ignore",   {31'd0, load_error}, 32'd1);
    send_byte(8'hA5);
    check_eq("restart_err",  {31'd0, load_error}, 32'd0);
    check_eq("restart_words", 32'(words_loaded),  32'd0);
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(32'h0000_0020);
    send_word(32'h1234_5678);
    send_byte(8'h28);
    check_eq("restart_done", {31'd0, load_done}, 32'd1);

    // Zero-length frame.
    clear_log();
    send_hdr(16'd0);
    send_byte(8'h00);
    check_eq("zero_done",  {31'd0, load_done}, 32'd1);
    check_eq("zero_nwr",   wa_q.size(),        32'd0);
    check_eq("zero_words", 32'(words_loaded),  32'd0);

    // Start marker inside a frame is data: A5^A5^01^02 = 03.
    clear_log();
    send_hdr(16'd1);
    send_word(32'hA5A5_0102);
    send_byte(8'h03);
    check_eq("inband_done", {31'd0, load_done}, 32'd1);
    check_eq("inband_d0",   wd_at(0),           32'hA5A5_0102);

    // Oversize length: error straight after LEN_LO, no writes.
    clear_log();
    send_hdr(16'h0401);
    check_eq("over_err", {31'd0, load_error}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("over_nwr", wa_q.size(), 32'd0);

    // Full-capacity image of 1024 words.
    clear_log();
    chk = 8'h00;
    send_hdr(16'h0400);
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w   = word_of(i);
      chk = chk ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      send_word(w);
    end
    send_byte(chk);
    bad = 0;
    for (int i = 0; i < 1024; i++)
      if (wa_at(i) !== 32'(i) || wd_at(i) !== word_of(i)) bad++;
    check_eq("full_done",  {31'd0, load_done}, 32'd1);
    check_eq("full_nwr",   wa_q.size(),        32'd1024);
    check_eq("full_bad",   bad,                32'd0);
    check_eq("full_last_a", wa_at(1023),       32'h3FF);
    check_eq("full_words", 32'(words_loaded),  32'h400);
    check_eq("full_rdy_low", rdy_low,          32'd1024);

    // Timeout after 3 data bytes: 15 idle cycles tolerated, 16th aborts.
    send_hdr(16'd2);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    repeat (15) @(posedge clk);
    #1;
    check_eq("tmo_15", {31'd0, load_error}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("tmo_16", {31'd0, load_error}, 32'd1);

    // Accept in the expiry cycle wins.
    send_byte(8'hA5);
    repeat (15) @(posedge clk);
    #1;
    send_byte(8'h00);
    check_eq("tmo_accept_wins", {31'd0, load_error}, 32'd0);

    // Reset mid-DATA, then a clean reload from address 0.
    send_byte(8'h02);
    send_word(32'h1122_3344);
    send_byte(8'h55);
    check_eq("pre_rst_words", 32'(words_loaded), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_words", 32'(words_loaded),  32'd0);
    check_eq("mid_rst_wdata", imem_wdata,         32'd0);
    check_eq("mid_rst_addr",  32'(imem_addr),     32'd0);
    check_eq("mid_rst_ready", {31'd0, rx_ready},  32'd1);
    check_eq("mid_rst_core",  {31'd0, core_rst_n}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
    send_hdr(16'd2);
    send_word(32'h0000_0020);
    send_word(32'h1234_5678);
    send_byte(8'h28);
    check_eq("reload_done", {31'd0, load_done}, 32'd1);
    check_eq("reload_a0",   wa_at(0),           32'd0);
    check_eq("reload_d1",   wd_at(1),           32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
